// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns, BCD blank code and FSM state type shared with the display drive path
//   SEG_0..SEG_9, SEG_BLANK : 7-bit active-low patterns, bit 6 = a ... bit 0 = g
//   BCD_BLANK               : digit code shown as a dark digit
//   seg_state_t             : capture FSM states
package seg_pkg;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] BCD_BLANK = 4'hF;
    typedef enum logic [1:0] {IDLE, SETTLE, HELD} seg_state_t;
endpackage

// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if: display bus inputs and captured-digit outputs of seg_scan_capture
//   master : drives seg_in/an_in/clear, observes the capture results
//   slave  : the capture block itself
interface seg_scan_capture_if #(parameter int N_DIGITS = 4);
    logic [6:0]            seg_in;
    logic [N_DIGITS-1:0]   an_in;
    logic                  clear;
    logic [4*N_DIGITS-1:0] digits_out;
    logic [N_DIGITS-1:0]   digit_valid;
    logic [4*N_DIGITS-1:0] frame_out;
    logic                  frame_strobe;
    logic                  error;
    modport master (output seg_in, an_in, clear,
                    input  digits_out, digit_valid, frame_out, frame_strobe, error);
    modport slave  (input  seg_in, an_in, clear,
                    output digits_out, digit_valid, frame_out, frame_strobe, error);
endinterface

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: inverse seven-segment lookup, pattern -> BCD plus a known flag
//   pattern : active-low abcdefg pattern
//   bcd     : decoded digit, BCD_BLANK for a dark digit or unknown pattern
//   known   : high when the pattern is one of the eleven legal patterns
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       known
);
    always_comb begin
        bcd   = BCD_BLANK;
        known = 1'b1;
        case (pattern)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BCD_BLANK;
            default:   known = 1'b0;
        endcase
    end
endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: recovers BCD digits from a multiplexed active-low seven-segment bus
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus.seg_in, bus.an_in : observed segment pattern and active-low anodes
//   bus.clear : synchronous clear of valid bits, frame mask and error
//   bus.digits_out, bus.digit_valid : live captured digits and their valid bits
//   bus.frame_out, bus.frame_strobe : snapshot on frame completion and its one-cycle pulse
//   bus.error : sticky unknown-pattern / multi-anode flag
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic               clk,
    input logic               rst_n,
    seg_scan_capture_if.slave bus
);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

    logic [6:0]            s_seg, p_seg;
    logic [N_DIGITS-1:0]   s_an, p_an, act, sel, mask, mask_n, valid;
    logic [4*N_DIGITS-1:0] digits, nd, frame;
    logic [7:0]            cnt, cnt_n;
    logic [IW-1:0]         idx;
    logic [3:0]            bcd;
    logic                  known, same, idle, one, fire, hit, bad, full, strobe, err;
    seg_state_t            state;

    seg_pattern_decode u_dec (.pattern(s_seg), .bcd(bcd), .known(known));

    assign act    = ~s_an;
    assign idle   = &s_an;
    assign same   = {s_an, s_seg} == {p_an, p_seg};
    // a non-idle sample has exactly one active anode when clearing its lowest set bit leaves zero
    assign one    = (act & (act - N_DIGITS'(1))) == '0;
    assign cnt_n  = cnt + 8'd1;
    assign fire   = state == SETTLE && same && cnt_n >= 8'(STABLE_CYCLES);
    assign hit    = fire && one && known;
    assign bad    = fire && !(one && known);
    assign sel    = N_DIGITS'(1) << idx;
    assign mask_n = mask | sel;
    assign full   = &mask_n;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (act[i]) idx = IW'(i);
    end

    always_comb begin
        nd = digits;
        if (hit) nd[4*idx +: 4] = bcd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg  <= SEG_BLANK;
            p_seg  <= SEG_BLANK;
            s_an   <= '1;
            p_an   <= '1;
            state  <= IDLE;
            cnt    <= '0;
            digits <= {N_DIGITS{BCD_BLANK}};
            frame  <= {N_DIGITS{BCD_BLANK}};
            valid  <= '0;
            mask   <= '0;
            strobe <= 1'b0;
            err    <= 1'b0;
        end else begin
            s_seg  <= bus.seg_in;
            s_an   <= bus.an_in;
            p_seg  <= s_seg;
            p_an   <= s_an;
            strobe <= 1'b0;
            digits <= nd;
            if (state == IDLE) begin
                if (!idle) begin
                    state <= SETTLE;
                    cnt   <= 8'd1;
                end
            end else if (!same) begin
                state <= idle ? IDLE : SETTLE;
                cnt   <= idle ? 8'd0 : 8'd1;
            end else if (state == SETTLE) begin
                cnt <= cnt_n;
                if (fire) state <= HELD;
            end
            // clear overrides the bookkeeping of a coincident capture, but the digit is still written
            if (bus.clear) begin
                valid <= '0;
                mask  <= '0;
                err   <= 1'b0;
            end else begin
                if (hit) begin
                    valid <= valid | sel;
                    mask  <= full ? '0 : mask_n;
                    if (full) begin
                        frame  <= nd;
                        strobe <= 1'b1;
                    end
                end
                if (bad) err <= 1'b1;
            end
        end
    end

    assign bus.digits_out   = digits;
    assign bus.digit_valid  = valid;
    assign bus.frame_out    = frame;
    assign bus.frame_strobe = strobe;
    assign bus.error        = err;
endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Recovers BCD digits from a multiplexed, active-low seven-segment display bus: the same `seg`/anode signals the display path drives, read in the opposite direction. Each anode slot's pattern must be stable for a programmable number of cycles. The block then inverse-decodes the pattern to BCD, stores it per digit, and emits a packed frame once every digit has been refreshed. It sits beside the display controller as a readback and self-check path for the calculator's result display, and it is also used by the board-level bench.

## Interface
Parameters:
- `N_DIGITS`, 4: number of multiplexed digits; the width of the anode bus.
- `STABLE_CYCLES`, 4: consecutive identical samples required before capture; legal range 2..255.

Ports:
- `clk`, in, 1: single system clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `seg_in`, in, 7: segment pattern, active-low, bit 6 = a … bit 0 = g.
- `an_in`, in, N_DIGITS: digit enables, active-low; bit i selects digit i.
- `clear`, in, 1: synchronous clear of the digit valid bits, the frame mask and `error`.
- `digits_out`, out, 4*N_DIGITS: live captured digits; digit i occupies bits [4i+3:4i].
- `digit_valid`, out, N_DIGITS: bit i is set once digit i has been captured since reset or clear.
- `frame_out`, out, 4*N_DIGITS: snapshot of `digits_out` taken when a frame completes.
- `frame_strobe`, out, 1: one-cycle pulse when `frame_out` updates.
- `error`, out, 1: sticky; set on an unknown pattern or on a multi-anode condition.

## Operation
- **Sampling:** `seg_in` and `an_in` are registered every cycle into `s_seg` and `s_an`. All decisions are made on these registered samples.
- **Anode classification:**
  - all ones: idle.
  - exactly one zero: slot i.
  - more than one zero: multi-anode fault.
- **FSM states:**
  - IDLE
    - stays in IDLE while idle.
    - goes to SETTLE on any non-idle sample, with `cnt`=1.
  - SETTLE
    - A sample equal to the previous one increments `cnt`.
    - Any change restarts `cnt` at 1. A change to idle goes to IDLE.
    - When `cnt` reaches `STABLE_CYCLES`, perform the capture action and go to HELD.
  - HELD
    - stays in HELD while samples are unchanged; no further captures.
    - a change goes to SETTLE (`cnt`=1), or to IDLE if the new sample is idle.
- **Capture action, valid slot i:**
  - Decode the pattern:
    - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
    - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
    - 1111111→4'hF (blank)
  - Write the decoded value to digit i and set `digit_valid[i]` and `mask[i]`.
  - Any other pattern: digit i and its mask bit are unchanged, and `error` is set.
- **Capture action, multi-anode:** set `error`; no digit is written.
- **Frame completion:** when a capture makes `mask` all ones:
  - `frame_out` ← the updated `digits_out`, including the digit just captured.
  - `frame_strobe` goes high for one cycle.
  - `mask` clears.
- **Clear and capture together:** `clear` wins. Valid bits, mask and `error` clear, and the capture's valid/mask/error updates are dropped. The digit value is still written. `clear` does not change the FSM state.
- **Arithmetic:** `cnt` is 8 bits and saturates at `STABLE_CYCLES`, so it never wraps. Comparisons are on the full {`s_an`, `s_seg`} vector.

## Timing
- **Reset values:** `digits_out`=all 4'hF, `digit_valid`=0, `frame_out`=all 4'hF, `frame_strobe`=0, `error`=0, FSM=IDLE, `cnt`=0, `mask`=0.
- **Reset is asynchronous:** assertion forces reset values immediately, including mid-SETTLE or while `frame_strobe` is high. Deassertion is synchronised externally.
- **Capture latency:** let the inputs become stable before edge E0, so that edge registers the new value.
  - The capture registers update on edge E0+`STABLE_CYCLES`.
  - `frame_strobe` asserts on that same edge and lasts exactly one cycle.
- **Glitch rejection:** a pattern held for `STABLE_CYCLES`−1 cycles or fewer is never captured.
- **Frame rate:** at most one `frame_strobe` per `N_DIGITS` captures. There are no back-to-back strobes unless `N_DIGITS`=1.

## Structure
- Package `seg_pkg`:
  - `SEG_0`..`SEG_9`, `SEG_BLANK` (7-bit active-low abcdefg patterns).
  - `BCD_BLANK`=4'hF.
  - FSM state enum {IDLE, SETTLE, HELD}.
  - These are shared with the display drive path.
- Sub-module `seg_pattern_decode`:
  - combinational 7→4 inverse lookup plus a `known` flag.
  - the single place where the pattern table lives.

## Test plan
- **Single digit:** `an_in`=1110, `seg_in`=0000110 held 4 cycles → at E0+4, `digits_out`[3:0]=3 and `digit_valid`=0001; `frame_strobe`=0.
- **Glitch rejection:** pattern held 3 cycles, then `an_in`=1111 → no update, `digit_valid`=0, FSM back to IDLE.
- **Full scan:** digits 0..3 show 1,2,3,4, each held 6 cycles → `frame_out`=16'h4321 and `frame_strobe` high for exactly 1 cycle after the digit-3 capture. A second scan produces a second strobe.
- **Unknown pattern:** `seg_in`=1111110 on slot 2 held 4 cycles → `error`=1 and digit 2 unchanged. Then `clear`=1 for 1 cycle → `error`=0 and `digit_valid`=0.
- **Multi-anode:** `an_in`=1100 stable 4 cycles → `error`=1; `digits_out` unchanged.
- **Reset and clear edge cases:**
  - `rst_n` low mid-SETTLE → all outputs take their reset values immediately.
  - `clear` coincident with the completing capture → no `frame_strobe` and mask=0.
